param_cpu: RTL and testbench
============================

PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter WIDTH, default 8, datapath/operand width in bits (>=4).
REQ-002 Parameter PROG_DEPTH, default 16, instruction memory entries (power of two, >=2); AW = clog2(PROG_DEPTH).
REQ-003 Derived INSTR_W = 4 + 2*WIDTH; instruction word = {opcode[3:0], A[WIDTH-1:0], B[WIDTH-1:0]}.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 next_out  input  1  step request; rising edge advances to next instruction.
REQ-007 prog_we  input  1  program memory write enable.
REQ-008 prog_addr  input  AW  program memory write address.
REQ-009 prog_data  input  INSTR_W  program memory write data.
REQ-010 opcode  output  4  opcode of current instruction.
REQ-011 operand_A_out  output  WIDTH  operand A of current instruction.
REQ-012 operand_B_out  output  WIDTH  operand B of current instruction.
REQ-013 result_out_cpu  output  WIDTH  ALU result.
REQ-014 carry_out_cpu  output  1  carry flag.
REQ-015 borrow_out_cpu  output  1  borrow flag.
REQ-016 result_ready  output  1  result/flags valid, held until step.
REQ-017 pc_out  output  AW  address of current instruction.
REQ-018 halted  output  1  HALT executed; core stopped.

Function
REQ-019 FSM states FETCH, DECODE, EXEC, WAIT, HALTED; all outputs registered.
REQ-020 FETCH: synchronous read of mem[pc] -> DECODE next cycle.
REQ-021 DECODE: latch opcode, operand_A_out, operand_B_out -> EXEC.
REQ-022 EXEC: register result/flags, result_ready=1 -> WAIT; HALT opcode instead -> HALTED, halted=1, result_ready stays 0.
REQ-023 Latency: result_ready rises on the 3rd rising clk edge after FETCH entry.
REQ-024 WAIT: outputs frozen until next_out rising edge (next_out=1 and previous-cycle sample=0); then result_ready=0, pc=pc+1 (PROG_DEPTH-1 wraps to 0), -> FETCH.
REQ-025 next_out edges outside WAIT ignored, never queued; HALTED exits only by reset.
REQ-026 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT(A), 7 SHL(A by 1), 8 SHR(A by 1, logical), 15 HALT; 9-14 behave as NOP.
REQ-027 ADD: result=(A+B) mod 2^WIDTH, carry=bit WIDTH of unsigned sum, borrow=0.
REQ-028 SUB: result=(A-B) mod 2^WIDTH, borrow=1 iff A<B unsigned, carry=0.
REQ-029 SHL carry=A[WIDTH-1]; SHR carry=A[0]; all other ops carry=0, borrow=0; NOP result=0.
REQ-030 Program writes accepted in any state; write to address being read same cycle returns old data (read-before-write).
REQ-031 Memory contents not cleared by reset; unwritten entries undefined to software.

Reset
REQ-032 rst asserted (any state, including mid-EXEC/WAIT): state=FETCH, pc_out=0, opcode/operands/result=0, carry/borrow/result_ready/halted=0, next_out history=0.
REQ-033 First FETCH of mem[0] occurs on first clk edge after rst deasserts.

Structure
REQ-034 Package cpu_pkg holds opcode constants, FSM state encoding, INSTR_W derivation function.
REQ-035 One combinational sub-module param_alu (WIDTH param; opcode, A, B in; result, carry, borrow out).

Verification (WIDTH=8, PROG_DEPTH=16)
REQ-036 Load ADD 100,50 at 0 -> result 150, carry 0, result_ready 3 edges after reset release, pc_out 0.
REQ-037 ADD 200,100 -> result 44, carry 1; SUB 5,10 -> result 251, borrow 1.
REQ-038 Hold next_out high across WAIT entry, no new edge -> pc stays 0; 0->1 edge -> pc 1, result_ready drops.
REQ-039 Fill all 16 entries NOP, step 16 times -> pc_out wraps 15->0.
REQ-040 HALT at address 2 -> halted=1, result_ready=0, further next_out edges ignored; rst -> pc 0, halted 0.
REQ-041 rst pulsed during WAIT with result 150 -> all outputs 0 asynchronously, fresh fetch of mem[0] after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state encoding and instruction-width helper
// for the parameterised step-through CPU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WAIT,
    HALTED
  } cpu_state_t;

  // Instruction word is {opcode[3:0], A, B}.
  function automatic int instr_w(input int width);
    return 4 + 2 * width;
  endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational ALU: result plus carry/borrow flags for one decoded instruction.
module param_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    carry  = 1'b0;
    borrow = 1'b0;
    case (opcode)
      OP_NOP: result = '0;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        borrow = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      // 9-14 and HALT produce no result
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/param_cpu.sv
// Step-through CPU: fetches one instruction, executes it, then holds the
// result until a rising edge on next_out advances the program counter.
//
// state  | meaning
// FETCH  | synchronous read of mem[pc]
// DECODE | latch opcode and operands from the read word
// EXEC   | register ALU result/flags, or stop on HALT
// WAIT   | outputs frozen until a next_out rising edge
// HALTED | core stopped; only reset leaves this state
module param_cpu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PROG_DEPTH = 16,
  localparam int AW = $clog2(PROG_DEPTH),
  localparam int INSTR_W = instr_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               next_out,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         opcode,
  output logic [WIDTH-1:0]   operand_A_out,
  output logic [WIDTH-1:0]   operand_B_out,
  output logic [WIDTH-1:0]   result_out_cpu,
  output logic               carry_out_cpu,
  output logic               borrow_out_cpu,
  output logic               result_ready,
  output logic [AW-1:0]      pc_out,
  output logic               halted
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic [INSTR_W-1:0] rd_data;
  cpu_state_t         state;
  logic               next_q;
  logic               next_rise;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_borrow;

  assign next_rise = next_out & ~next_q;

  // Program memory is deliberately outside reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    if (state == FETCH)
      rd_data <= mem[pc_out];
  end

  param_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (opcode),
    .a      (operand_A_out),
    .b      (operand_B_out),
    .result (alu_result),
    .carry  (alu_carry),
    .borrow (alu_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      pc_out         <= '0;
      opcode         <= '0;
      operand_A_out  <= '0;
      operand_B_out  <= '0;
      result_out_cpu <= '0;
      carry_out_cpu  <= 1'b0;
      borrow_out_cpu <= 1'b0;
      result_ready   <= 1'b0;
      halted         <= 1'b0;
      next_q         <= 1'b0;
    end else begin
      next_q <= next_out;
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          opcode        <= rd_data[INSTR_W-1 -: 4];
          operand_A_out <= rd_data[2*WIDTH-1 -: WIDTH];
          operand_B_out <= rd_data[WIDTH-1:0];
          state         <= EXEC;
        end
        EXEC: begin
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else begin
            result_out_cpu <= alu_result;
            carry_out_cpu  <= alu_carry;
            borrow_out_cpu <= alu_borrow;
            result_ready   <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (next_rise) begin
            result_ready <= 1'b0;
            pc_out       <= pc_out + AW'(1);
            state        <= FETCH;
          end
        end
        HALTED: state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// Scoreboard bench for param_cpu: stimulus pushes expected results computed
// from opcode arithmetic; a monitor pops one entry on each result_ready rise.
module tb_param_cpu;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          next_out;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [3:0]    opcode;
  logic [7:0]    operand_A_out;
  logic [7:0]    operand_B_out;
  logic [7:0]    result_out_cpu;
  logic          carry_out_cpu;
  logic          borrow_out_cpu;
  logic          result_ready;
  logic [AW-1:0] pc_out;
  logic          halted;

  param_cpu #(.WIDTH(WIDTH), .PROG_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_out       (next_out),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .opcode         (opcode),
    .operand_A_out  (operand_A_out),
    .operand_B_out  (operand_B_out),
    .result_out_cpu (result_out_cpu),
    .carry_out_cpu  (carry_out_cpu),
    .borrow_out_cpu (borrow_out_cpu),
    .result_ready   (result_ready),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int op;
    int a;
    int b;
    int res;
    int c;
    int br;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] model_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            pc_m = 0;
  logic          prev_rr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int op, input int a, input int b);
    return {op[3:0], a[7:0], b[7:0]};
  endfunction

  // Reference: plain integer arithmetic on unsigned 8-bit values
  function automatic exp_t model(input int pc, input logic [IW-1:0] w);
    exp_t e;
    int a, b;
    a = int'(w[15:8]);
    b = int'(w[7:0]);
    e.pc = pc; e.op = int'(w[19:16]); e.a = a; e.b = b;
    e.res = 0; e.c = 0; e.br = 0;
    case (e.op)
      1: begin e.res = (a + b) % 256; e.c = (a + b >= 256) ? 1 : 0; end
      2: begin e.res = (a - b + 256) % 256; e.br = (a < b) ? 1 : 0; end
      3: e.res = a & b;
      4: e.res = a | b;
      5: e.res = a ^ b;
      6: e.res = 255 - a;
      7: begin e.res = (a * 2) % 256; e.c = (a >= 128) ? 1 : 0; end
      8: begin e.res = a / 2; e.c = a % 2; end
      default: e.res = 0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (result_ready === 1'b1 && prev_rr !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected pc %0d result %0d expected none", pc_out, result_out_cpu);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc", int'(pc_out), e.pc);
        chk("mon_opcode", int'(opcode), e.op);
        chk("mon_a", int'(operand_A_out), e.a);
        chk("mon_b", int'(operand_B_out), e.b);
        chk("mon_result", int'(result_out_cpu), e.res);
        chk("mon_carry", int'(carry_out_cpu), e.c);
        chk("mon_borrow", int'(borrow_out_cpu), e.br);
      end
    end
    prev_rr <= result_ready;
  end

  task automatic load(input int addr, input logic [IW-1:0] w);
    model_mem[addr] = w;
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[AW-1:0];
    prog_data = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (result_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, int'(result_ready === 1'b1), 1);
  endtask

  task automatic step();
    int nxt;
    wait_ready("step");
    nxt = (pc_m + 1) % DEPTH;
    if (model_mem[nxt][19:16] != 4'hF)
      sb.push_back(model(nxt, model_mem[nxt]));
    next_out = 1'b1;
    @(negedge clk);
    chk("step_drop", int'(result_ready), 0);
    chk("step_pc", int'(pc_out), nxt);
    next_out = 1'b0;
    pc_m = nxt;
  endtask

  // Async assert away from clock edges, check cleared outputs, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    next_out = 1'b0;
    #1;
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_opcode", int'(opcode), 0);
    chk("rst_a", int'(operand_A_out), 0);
    chk("rst_b", int'(operand_B_out), 0);
    chk("rst_result", int'(result_out_cpu), 0);
    chk("rst_carry", int'(carry_out_cpu), 0);
    chk("rst_borrow", int'(borrow_out_cpu), 0);
    chk("rst_ready", int'(result_ready), 0);
    chk("rst_halted", int'(halted), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc_m = 0;
    if (model_mem[0][19:16] != 4'hF)
      sb.push_back(model(0, model_mem[0]));
  endtask

  initial begin
    int n;
    rst = 1'b1; next_out = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    load(0, mk(1, 100, 50));
    load(1, mk(1, 200, 100));
    load(2, mk(2, 5, 10));
    for (int i = 3; i < DEPTH; i++)
      load(i, mk($urandom_range(0, 14), $urandom_range(0, 255), $urandom_range(0, 255)));

    // Latency, plus next_out raised before WAIT and held: must not step
    do_reset();
    next_out = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("lat_edge2", int'(result_ready), 0);
    @(posedge clk);
    #1 chk("lat_edge3", int'(result_ready), 1);
    chk("lat_result", int'(result_out_cpu), 150);
    repeat (6) @(negedge clk);
    chk("hold_pc", int'(pc_out), 0);
    chk("hold_ready", int'(result_ready), 1);
    next_out = 1'b0;
    @(negedge clk);
    step();

    for (int i = 0; i < 20; i++) step();

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, mk($urandom_range(0, 14), $urandom_range(0, 255), $urandom_range(0, 255)));
      do_reset();
      for (int i = 0; i < 18; i++) step();
    end

    // All NOP-class opcodes, wrap 15 -> 0
    for (int i = 0; i < DEPTH; i++) begin
      n = $urandom_range(0, 6);
      load(i, mk((n == 0) ? 0 : n + 8, $urandom_range(0, 255), $urandom_range(0, 255)));
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) step();
    wait_ready("wrap");
    chk("wrap_pc", int'(pc_out), 0);

    // Reset pulsed in WAIT, then fresh fetch of mem[0]
    load(0, mk(1, 100, 50));
    do_reset();
    wait_ready("pre_wait_rst");
    chk("pre_wait_rst_result", int'(result_out_cpu), 150);
    do_reset();
    wait_ready("post_wait_rst");
    chk("post_wait_rst_pc", int'(pc_out), 0);
    chk("post_wait_rst_result", int'(result_out_cpu), 150);

    // HALT at address 2
    load(1, mk(0, 7, 9));
    load(2, mk(15, 3, 4));
    do_reset();
    step();
    step();
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("halt_flag", int'(halted === 1'b1), 1);
    chk("halt_ready", int'(result_ready), 0);
    chk("halt_opcode", int'(opcode), 15);
    chk("halt_pc", int'(pc_out), 2);
    repeat (3) begin
      next_out = 1'b1;
      @(negedge clk);
      next_out = 1'b0;
      @(negedge clk);
    end
    chk("halt_stay_pc", int'(pc_out), 2);
    chk("halt_stay_flag", int'(halted), 1);
    chk("halt_stay_ready", int'(result_ready), 0);
    do_reset();
    wait_ready("after_halt");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
